// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit control slice.
// Holds the arbiter FSM state encoding and a width helper.
package uart_ctrl_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } tx_arb_state_t;

  // Ceiling log2; constant-evaluable for parameter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above i_ptr, wrapping.
// Zero latency; no state, so no backpressure of its own.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int              w_j;
  logic [IW-1:0]   w_jx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    w_jx  = '0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      w_jx = IW'(w_j);
      if (!o_any && i_req[w_jx]) begin
        o_gnt[w_jx] = 1'b1;
        o_idx       = w_jx;
        o_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter; accept-to-uart_en is 1 cycle.
// req_ready only in IDLE with tx_busy low, so sources stall while a frame is in flight.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int N_REQ         = 4,
  parameter  int DATA_W        = UART_DATA_W,
  parameter  int START_TIMEOUT = 64,
  localparam int GW            = clog2(N_REQ),
  localparam int TW            = clog2(START_TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       uart_data,
  output logic                    uart_en,
  input  logic                    tx_busy,
  output logic [GW-1:0]           grant_id,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    err_timeout
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] IDX_LAST   = GW'(N_REQ - 1);

  tx_arb_state_t     r_state;
  tx_arb_state_t     w_state_nxt;
  logic [GW-1:0]     r_ptr;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_timer_nxt;
  logic [DATA_W-1:0] r_data;
  logic [GW-1:0]     r_gid;
  logic              r_en;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [N_REQ-1:0]  w_gnt;
  logic [GW-1:0]     w_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_timeout;
  logic              w_finish;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_timer_nxt = (r_timer == TIMER_LAST) ? r_timer : r_timer + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    req_ready   = '0;
    case (r_state)
      IDLE: begin
        if (w_any && !tx_busy) begin
          w_accept    = 1'b1;
          req_ready   = w_gnt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = WAIT_DONE;
        end else if (w_timer_nxt == TIMER_LAST) begin
          // Transmitter never started: drop the byte rather than retry.
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_timer <= '0;
      r_data  <= '0;
      r_gid   <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_en    <= w_accept;
      r_done  <= w_finish;
      if (w_timeout) r_err <= 1'b1;
      if (w_accept) begin
        r_data <= req_data[w_idx*DATA_W +: DATA_W];
        r_gid  <= w_idx;
        r_ptr  <= (w_idx == IDX_LAST) ? '0 : w_idx + 1'b1;
      end
      if (r_state == ISSUE) begin
        r_timer <= '0;
      end else if (r_state == WAIT_BUSY && !tx_busy) begin
        r_timer <= w_timer_nxt;
      end
    end
  end

  assign uart_data   = r_data;
  assign uart_en     = r_en;
  assign grant_id    = r_gid;
  assign busy        = r_busy;
  assign frame_done  = r_done;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, scoreboard of expected bytes/ids,
// and a small UART transmitter model driving tx_busy.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] uart_data;
  logic          uart_en;
  logic          tx_busy;
  logic [1:0]    grant_id;
  logic          busy;
  logic          frame_done;
  logic          err_timeout;

  logic force_mode;
  logic force_val;
  logic m_busy;
  int   m_st;
  int   m_cnt;
  logic [7:0] m_byte;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         id_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] valid;
    logic [7:0] base;
    int         exp_id;
  } vec_t;
  vec_t vecs[8];

  assign tx_busy = force_mode ? force_val : m_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ         (N),
    .DATA_W        (DW),
    .START_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .uart_en     (uart_en),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  // UART model: busy rises 3 cycles after data_en, stays up 6 cycles, then delivers the byte.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_st   <= 0;
      m_cnt  <= 0;
      m_busy <= 1'b0;
      m_byte <= '0;
    end else begin
      case (m_st)
        0: if (uart_en && !force_mode) begin
             m_byte <= uart_data;
             m_cnt  <= 2;
             m_st   <= 1;
           end
        1: if (m_cnt == 1) begin
             m_busy <= 1'b1;
             m_cnt  <= 6;
             m_st   <= 2;
           end else m_cnt <= m_cnt - 1;
        default: if (m_cnt == 1) begin
             m_busy <= 1'b0;
             rx_q.push_back(m_byte);
             m_st   <= 0;
           end else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_lanes(input logic [7:0] base, input int step);
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = base + 8'(i * step);
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    while (req_ready == '0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_bound", 32'(waited < 50), 1);
  endtask

  task automatic issue_check(input string nm, input logic [7:0] eb, input bit drop);
    @(posedge clk);
    #1;
    if (drop) begin
      req_valid = '0;
      req_data  = $urandom;
    end
    @(negedge clk);
    chk({nm, "_uart_en"}, 32'(uart_en), 1);
    chk({nm, "_uart_data"}, 32'(uart_data), 32'(eb));
    chk({nm, "_busy_issue"}, 32'(busy), 1);
    chk({nm, "_ready_low"}, 32'(req_ready), 0);
  endtask

  task automatic wait_done(input string nm);
    int cnt;
    int extra;
    logic [7:0] eb;
    int eid;
    cnt   = 0;
    extra = 0;
    while (!frame_done && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (uart_en) extra++;
    end
    chk({nm, "_done_seen"}, 32'(frame_done), 1);
    chk({nm, "_extra_en"}, extra, 0);
    chk({nm, "_busy_done"}, 32'(busy), 0);
    if (exp_q.size() > 0) begin
      eb  = exp_q.pop_front();
      eid = id_q.pop_front();
      chk({nm, "_grant_id"}, 32'(grant_id), eid);
      if (rx_q.size() > 0) chk({nm, "_rx_byte"}, 32'(rx_q.pop_front()), 32'(eb));
      else chk({nm, "_rx_present"}, 0, 1);
    end else begin
      chk({nm, "_sb_nonempty"}, 0, 1);
    end
  endtask

  task automatic do_frame(input logic [3:0] v, input logic [7:0] base, input int exp_id,
                          input string nm, output int waited);
    logic [7:0] eb;
    @(posedge clk);
    #1;
    req_valid = v;
    set_lanes(base, 16);
    eb = base + 8'(exp_id * 16);
    exp_q.push_back(eb);
    id_q.push_back(exp_id);
    @(negedge clk);
    wait_ready(waited);
    chk({nm, "_ready"}, 32'(req_ready), 32'(1 << exp_id));
    issue_check(nm, eb, 1'b1);
    wait_done(nm);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 32'(frame_done), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    int cnt;
    int fd;
    int order[5];
    vecs[0] = '{4'b0100, 8'h85, 2};
    vecs[1] = '{4'b1001, 8'h01, 3};
    vecs[2] = '{4'b1001, 8'h02, 0};
    vecs[3] = '{4'b1001, 8'h03, 3};
    vecs[4] = '{4'b0110, 8'h04, 1};
    vecs[5] = '{4'b0011, 8'h05, 0};
    vecs[6] = '{4'b1111, 8'h06, 1};
    vecs[7] = '{4'b1000, 8'h07, 3};
    order   = '{0, 1, 2, 3, 0};

    force_mode = 1'b0;
    force_val  = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    rstn       = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_uart_en", 32'(uart_en), 0);
    chk("rst_uart_data", 32'(uart_data), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++)
      do_frame(vecs[i].valid, vecs[i].base, vecs[i].exp_id, $sformatf("vec%0d", i), w);

    // All four held: strict 0,1,2,3,0 with each grant in the frame_done cycle.
    @(posedge clk);
    #1;
    req_valid = 4'hF;
    set_lanes(8'h10, 1);
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'h10 + 8'(order[k]));
      id_q.push_back(order[k]);
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      wait_ready(w);
      if (k > 0) chk("rr_back_to_back", w, 0);
      chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(1 << order[k]));
      issue_check("rr", 8'h10 + 8'(order[k]), k == 4);
      wait_done("rr");
    end
    @(negedge clk);
    chk("rr_done_pulse", 32'(frame_done), 0);

    // Start timeout with tx_busy held low.
    force_mode = 1'b1;
    force_val  = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    set_lanes(8'h70, 16);
    @(negedge clk);
    wait_ready(w);
    chk("to_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    chk("to_uart_en", 32'(uart_en), 1);
    cnt = 0;
    fd  = 0;
    while (!err_timeout && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (frame_done) fd++;
    end
    chk("to_cycles", cnt, TO);
    chk("to_err", 32'(err_timeout), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_no_done", fd, 0);
    @(negedge clk);
    chk("to_no_done_after", 32'(frame_done), 0);
    chk("to_no_rx", rx_q.size(), 0);
    force_mode = 1'b0;
    do_frame(4'b0001, 8'h20, 0, "to_next", w);
    chk("to_err_sticky", 32'(err_timeout), 1);

    // tx_busy high in IDLE blocks the grant until it falls.
    force_mode = 1'b1;
    force_val  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    set_lanes(8'h40, 16);
    exp_q.push_back(8'h60);
    id_q.push_back(2);
    repeat (6) begin
      @(negedge clk);
      chk("blk_ready", 32'(req_ready), 0);
    end
    chk("blk_idle", 32'(busy), 0);
    @(posedge clk);
    #1;
    force_mode = 1'b0;
    @(negedge clk);
    chk("blk_release_ready", 32'(req_ready), 32'b0100);
    issue_check("blk", 8'h60, 1'b1);
    wait_done("blk");

    // Reset during WAIT_DONE; ptr was 3, so 1001 must go to requester 0 afterwards.
    @(posedge clk);
    #1;
    req_valid = 4'b0100;
    set_lanes(8'h50, 16);
    @(negedge clk);
    wait_ready(w);
    chk("rst_mid_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    cnt = 0;
    while (!tx_busy && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
    chk("rst_mid_txbusy", 32'(tx_busy), 1);
    @(negedge clk);
    chk("rst_mid_busy_pre", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_uart_en", 32'(uart_en), 0);
    chk("rst_mid_uart_data", 32'(uart_data), 0);
    chk("rst_mid_grant_id", 32'(grant_id), 0);
    chk("rst_mid_err", 32'(err_timeout), 0);
    chk("rst_mid_done", 32'(frame_done), 0);
    chk("rst_mid_ready0", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_mid_no_rx", rx_q.size(), 0);
    do_frame(4'b1001, 8'h08, 0, "post_rst", w);

    chk("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

- Shares the single UART transmitter between `N_REQ` independent byte sources.
- Uses round-robin arbitration with a valid/ready handshake on each requester port.
- Sequences each accepted byte through the transmitter's `data_en`/`tx_busy` interface, one frame at a time.
- Sits between the command/status producers and the `uart` block's transmit inputs, and watches for a transmitter that never starts.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `DATA_W`, default 8: byte width; must match the UART data width.
- `START_TIMEOUT`, default 64: cycles to wait for `tx_busy` to rise after issue before aborting; must be ≥2.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `req_valid` in `N_REQ`: requester i has a byte pending.
- `req_data` in `N_REQ*DATA_W`: requester i's byte occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out `N_REQ`: one-hot acceptance; a byte transfers when `req_valid[i] & req_ready[i]` on a clock edge.
- `uart_data` out `DATA_W`: byte to the UART `data_in`; holds the captured byte.
- `uart_en` out 1: UART `data_en`, high for exactly one cycle per frame.
- `tx_busy` in 1: UART transmitter busy flag.
- `grant_id` out `$clog2(N_REQ)`: index of the requester owning the current or last frame.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when a frame completes normally.
- `err_timeout` out 1: sticky flag set on a start timeout; cleared only by reset.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - A grant is issued when `|req_valid` and `tx_busy==0`.
  - The round-robin arbiter picks the winner: the first set bit at or above `ptr`, wrapping modulo `N_REQ`.
  - `req_ready[winner]` is driven combinationally in that same cycle.
  - On the edge: `uart_data` ← the winner's byte, `grant_id` ← winner, `ptr` ← (winner+1) mod `N_REQ`, state → ISSUE.
  - If `tx_busy` is high, no grant is issued and all `req_ready` bits stay low.
- ISSUE: `uart_en`=1 for this single cycle; state → WAIT_BUSY; `timer` is cleared.
- WAIT_BUSY:
  - If `tx_busy`==1, state → WAIT_DONE.
  - Otherwise `timer` increments. When `timer` reaches `START_TIMEOUT-1` with `tx_busy` still low: set `err_timeout`, state → IDLE. The byte is dropped, with no retry and no `frame_done`.
- WAIT_DONE: when `tx_busy`==0, pulse `frame_done` on the next cycle and return to IDLE.
- `timer` width is `$clog2(START_TIMEOUT)`; it saturates and never wraps.
- `req_valid` deasserting mid-frame has no effect once the byte is captured.
- Bits of `req_data` for non-granted requesters are ignored.
- Reset mid-frame: the FSM returns to IDLE immediately. `uart_en` drops asynchronously; the byte in flight in the UART is not tracked.

## Timing
- Reset values: state=IDLE, `ptr`=0, `uart_data`=0, `uart_en`=0, `req_ready`=0, `grant_id`=0, `busy`=0, `frame_done`=0, `err_timeout`=0.
- Acceptance-to-`uart_en`: 1 cycle; the acceptance edge is cycle 0 and `uart_en` is high in cycle 1.
- `frame_done` is registered: it is high for the one cycle after `tx_busy` is sampled low in WAIT_DONE, and state is IDLE during that cycle.
- Back-to-back: the next grant can be issued in the same cycle that `frame_done` is high.
- `req_ready` is never asserted while `busy`=1, and at most one bit is high in any cycle.
- All outputs are registered except `req_ready`, which is decoded from state, `req_valid` and `ptr`.

## Structure
- Package `uart_ctrl_pkg` holds:
  - the state enum `tx_arb_state_t` {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE};
  - the `UART_DATA_W`=8 constant;
  - a `clog2` helper function.
- Sub-module `rr_arbiter`:
  - purely combinational;
  - inputs: request vector and `ptr`;
  - outputs: one-hot grant, binary index and any-grant flag.
- Top level holds the FSM, the byte capture register, `timer` and `ptr`, and is instantiated beside `uart` with `uart_data`/`uart_en` wired to `data_in`/`data_en`.

## Test plan
- **Single request:** `req_valid`=4'b0100, byte 0xA5, UART looped back → `req_ready`=4'b0100 for 1 cycle; `uart_en` 1 cycle later; UART receives 0xA5; one `frame_done`; `grant_id`=2.
- **Round-robin fairness:** all four valid and held, bytes 0x10..0x13 → service order 0,1,2,3,0; no requester is granted twice before the others.
- **Wrap-around pointer:** first grant requester 3, then `req_valid`=4'b1001 → requester 0 is granted next, not requester 3.
- **Start timeout:** `tx_busy` tied to 0, one request → `err_timeout` sets exactly `START_TIMEOUT` cycles after `uart_en`; FSM is IDLE; no `frame_done`; the next request is still served.
- **Busy blocking:** `tx_busy` forced to 1 in IDLE with requests pending → `req_ready` stays 0 until `tx_busy` falls; grant follows in that same cycle.
- **Reset mid-frame:** `rstn` pulsed low during WAIT_DONE → all outputs return to reset values asynchronously; `err_timeout` clears; `ptr`=0, so requester 0 is granted first afterward.
